jt89_regs: RTL

- CPU-side register file and write sequencer for the SN76489-compatible PSG.
- Decodes latch and data bytes into tone periods, channel volumes and the noise control word.
- Issues the noise-LFSR clear pulse whenever the noise control register is written.
- Drives a READY handshake that models the chip's busy time after each write; sits between the CPU bus and the tone/noise channel blocks.

---
 rtl/jt89_regs.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jt89_regs.sv
// jt89_regs: CPU-side register file and write sequencer for an SN76489-compatible PSG.
// Decodes latch/data bytes into tone periods, attenuations and the noise control word,
// raises the noise-LFSR clear request on ctrl3 writes, and models the chip busy time on ready.
// Optional feature macro: JT89_REGS_READBACK_EN adds rd_addr/dout register readback.
module jt89_regs #(
   parameter int unsigned BUSY_CYCLES = 32,
   parameter int unsigned CW          = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        cs_n,
   input  logic        wr_n,
   input  logic [7:0]  din,
`ifdef JT89_REGS_READBACK_EN
   input  logic [2:0]  rd_addr,
   output logic [9:0]  dout,
`endif
   output logic        ready,
   output logic [9:0]  tone0,
   output logic [9:0]  tone1,
   output logic [9:0]  tone2,
   output logic [3:0]  vol0,
   output logic [3:0]  vol1,
   output logic [3:0]  vol2,
   output logic [3:0]  vol3,
   output logic [2:0]  ctrl3,
   output logic        clr
);

   logic [2:0]    idx_q,   idx_d;
   logic [9:0]    tone_q [3];
   logic [9:0]    tone_d [3];
   logic [3:0]    vol_q  [4];
   logic [3:0]    vol_d  [4];
   logic [2:0]    ctrl3_q, ctrl3_d;
   logic          clr_q,   clr_d;
   logic          ready_q, ready_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          stb_q,   stb_d;

   logic          stb;
   logic          accept;
   logic [2:0]    wr_idx;

   // Latch byte rewrites the low nibble; data byte rewrites the upper six bits.
   function automatic logic [9:0] tone_wr(input logic [9:0] old, input logic [7:0] d);
      tone_wr = d[7] ? {old[9:4], d[3:0]} : {d[5:0], old[3:0]};
   endfunction

   // Write decode, noise clear request and busy countdown.
   always_comb begin
      idx_d   = idx_q;
      tone_d  = tone_q;
      vol_d   = vol_q;
      ctrl3_d = ctrl3_q;
      clr_d   = clr_q & ~clk_en;
      ready_d = ready_q;
      cnt_d   = cnt_q;

      stb     = ~cs_n & ~wr_n;
      stb_d   = stb;
      accept  = stb & ~stb_q & ready_q;
      wr_idx  = din[7] ? din[6:4] : idx_q;

      if (accept) begin
         if (din[7]) idx_d = din[6:4];
         case (wr_idx)
            3'd0: tone_d[0] = tone_wr(tone_q[0], din);
            3'd1: vol_d[0]  = din[3:0];
            3'd2: tone_d[1] = tone_wr(tone_q[1], din);
            3'd3: vol_d[1]  = din[3:0];
            3'd4: tone_d[2] = tone_wr(tone_q[2], din);
            3'd5: vol_d[2]  = din[3:0];
            3'd6: begin
               ctrl3_d = din[2:0];
               clr_d   = 1'b1;
            end
            default: vol_d[3] = din[3:0];
         endcase
      end

      if (accept && (BUSY_CYCLES != 0)) begin
         cnt_d   = CW'(BUSY_CYCLES);
         ready_d = 1'b0;
      end else if (!ready_q && clk_en) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) ready_d = 1'b1;
      end
   end

   // Register state; reset also drops any pending clear and busy period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= 3'd0;
         for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
         for (int i = 0; i < 4; i++) vol_q[i]  <= 4'hF;
         ctrl3_q <= 3'd0;
         clr_q   <= 1'b0;
         ready_q <= 1'b1;
         cnt_q   <= '0;
         stb_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         tone_q  <= tone_d;
         vol_q   <= vol_d;
         ctrl3_q <= ctrl3_d;
         clr_q   <= clr_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         stb_q   <= stb_d;
      end
   end

`ifdef JT89_REGS_READBACK_EN
   logic [9:0] dout_q, dout_d;

   // Readback mux over the index map, zero-extended.
   always_comb begin
      dout_d = 10'd0;
      case (rd_addr)
         3'd0: dout_d = tone_q[0];
         3'd1: dout_d = {6'd0, vol_q[0]};
         3'd2: dout_d = tone_q[1];
         3'd3: dout_d = {6'd0, vol_q[1]};
         3'd4: dout_d = tone_q[2];
         3'd5: dout_d = {6'd0, vol_q[2]};
         3'd6: dout_d = {7'd0, ctrl3_q};
         default: dout_d = {6'd0, vol_q[3]};
      endcase
   end

   // Readback register, one clk of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= 10'd0;
      else        dout_q <= dout_d;
   end

   assign dout = dout_q;
`endif

   assign ready = ready_q;
   assign tone0 = tone_q[0];
   assign tone1 = tone_q[1];
   assign tone2 = tone_q[2];
   assign vol0  = vol_q[0];
   assign vol1  = vol_q[1];
   assign vol2  = vol_q[2];
   assign vol3  = vol_q[3];
   assign ctrl3 = ctrl3_q;
   assign clr   = clr_q;

endmodule
